// File: rtl/eth_header_parser.sv
// Ethernet header parser: preamble/SFD hunt, then destination, source and type/length
// capture with run-time field checks, enable stalls, frame-end resync and error codes.
module eth_header_parser #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter bit          CHECK_DST    = 1'b1,
    parameter bit          CHECK_SRC    = 1'b1,
    parameter bit          CHECK_TYPE   = 1'b1,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [7:0]  data_i,
    input  logic        frame_end_i,
    input  logic [47:0] exp_dst_addr_i,
    input  logic [47:0] exp_src_addr_i,
    input  logic [15:0] exp_type_i,
    output logic        preamble_valid_o,
    output logic        dst_addr_valid_o,
    output logic        src_addr_valid_o,
    output logic        type_length_valid_o,
    output logic [47:0] dst_addr_o,
    output logic [47:0] src_addr_o,
    output logic [15:0] type_length_o,
    output logic        parse_error_o,
    output logic [1:0]  err_code_o,
    output logic        in_header_o
);

    typedef enum logic [2:0] {
        S_PREAMBLE,
        S_DST,
        S_SRC,
        S_TYPE,
        S_DONE
    } state_e;

    localparam logic [3:0] PRE_MIN = 4'(PREAMBLE_LEN);

    state_e      state_q;
    logic [3:0]  pre_cnt_q;
    logic [2:0]  byte_cnt_q;
    logic [39:0] shift_q;
    logic        pre_valid_q, dst_valid_q, src_valid_q, type_valid_q;
    logic        parse_error_q, in_header_q;
    logic [1:0]  err_code_q;
    logic [47:0] dst_addr_q, src_addr_q;
    logic [15:0] type_q;

    // Completed field values include the byte being sampled on this edge.
    logic [47:0] addr_d;
    logic [15:0] type_d;
    logic        dst_ok_d, src_ok_d, type_ok_d;

    assign addr_d    = {shift_q, data_i};
    assign type_d    = {shift_q[7:0], data_i};
    assign dst_ok_d  = !CHECK_DST || (addr_d == exp_dst_addr_i) || (ACCEPT_BCAST && (&addr_d));
    assign src_ok_d  = !CHECK_SRC || (addr_d == exp_src_addr_i);
    assign type_ok_d = !CHECK_TYPE || (type_d == exp_type_i);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_PREAMBLE;
            pre_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            pre_valid_q   <= 1'b0;
            dst_valid_q   <= 1'b0;
            src_valid_q   <= 1'b0;
            type_valid_q  <= 1'b0;
            parse_error_q <= 1'b0;
            in_header_q   <= 1'b0;
            err_code_q    <= '0;
            dst_addr_q    <= '0;
            src_addr_q    <= '0;
            type_q        <= '0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge state; pulses default low.
            pre_valid_q   <= 1'b0;
            dst_valid_q   <= 1'b0;
            src_valid_q   <= 1'b0;
            type_valid_q  <= 1'b0;
            parse_error_q <= 1'b0;
            if (frame_end_i) begin
                // NOTE: frame_end outranks enable, so a byte completing on this edge is dropped.
                state_q     <= S_PREAMBLE;
                pre_cnt_q   <= '0;
                byte_cnt_q  <= '0;
                in_header_q <= 1'b0;
            end else if (enable_i) begin
                case (state_q)
                    S_PREAMBLE: begin
                        if (data_i == 8'h55) begin
                            if (pre_cnt_q != 4'hF) pre_cnt_q <= pre_cnt_q + 4'd1;
                        end else if (data_i == 8'hD5 && pre_cnt_q >= PRE_MIN) begin
                            pre_valid_q <= 1'b1;
                            state_q     <= S_DST;
                            byte_cnt_q  <= '0;
                            pre_cnt_q   <= '0;
                            in_header_q <= 1'b1;
                        end else begin
                            pre_cnt_q <= '0;
                        end
                    end
                    S_DST: begin
                        shift_q <= {shift_q[31:0], data_i};
                        if (byte_cnt_q == 3'd5) begin
                            byte_cnt_q <= '0;
                            if (dst_ok_d) begin
                                dst_addr_q  <= addr_d;
                                dst_valid_q <= 1'b1;
                                state_q     <= S_SRC;
                            end else begin
                                parse_error_q <= 1'b1;
                                err_code_q    <= 2'b01;
                                state_q       <= S_PREAMBLE;
                                pre_cnt_q     <= '0;
                                in_header_q   <= 1'b0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                    S_SRC: begin
                        shift_q <= {shift_q[31:0], data_i};
                        if (byte_cnt_q == 3'd5) begin
                            byte_cnt_q <= '0;
                            if (src_ok_d) begin
                                src_addr_q  <= addr_d;
                                src_valid_q <= 1'b1;
                                state_q     <= S_TYPE;
                            end else begin
                                parse_error_q <= 1'b1;
                                err_code_q    <= 2'b10;
                                state_q       <= S_PREAMBLE;
                                pre_cnt_q     <= '0;
                                in_header_q   <= 1'b0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                    S_TYPE: begin
                        shift_q <= {shift_q[31:0], data_i};
                        if (byte_cnt_q == 3'd1) begin
                            byte_cnt_q  <= '0;
                            in_header_q <= 1'b0;
                            if (type_ok_d) begin
                                type_q       <= type_d;
                                type_valid_q <= 1'b1;
                                state_q      <= S_DONE;
                            end else begin
                                parse_error_q <= 1'b1;
                                err_code_q    <= 2'b11;
                                state_q       <= S_PREAMBLE;
                                pre_cnt_q     <= '0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                        state_q     <= S_PREAMBLE;
                        pre_cnt_q   <= '0;
                        byte_cnt_q  <= '0;
                        in_header_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign preamble_valid_o    = pre_valid_q;
    assign dst_addr_valid_o    = dst_valid_q;
    assign src_addr_valid_o    = src_valid_q;
    assign type_length_valid_o = type_valid_q;
    assign dst_addr_o          = dst_addr_q;
    assign src_addr_o          = src_addr_q;
    assign type_length_o       = type_q;
    assign parse_error_o       = parse_error_q;
    assign err_code_o          = err_code_q;
    assign in_header_o         = in_header_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Bench for eth_header_parser: directed vector table, hand-written corner sequences and
// random frames, all compared against a byte-history reference model for two configurations.
module tb_eth_header_parser;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        frame_end = 1'b0;
    logic [47:0] exp_dst = 48'h010203040506;
    logic [47:0] exp_src = 48'hFFFEFDFCFBFA;
    logic [15:0] exp_type = 16'h0800;

    logic        pv[2], dv[2], sv[2], tv[2], pe[2], inh[2];
    logic [1:0]  ec[2];
    logic [47:0] dsto[2], srco[2];
    logic [15:0] tyo[2];

    int total = 0;
    int bad = 0;
    int stall_pct = 0;

    always #5 clock = ~clock;

    // Instance 0: default configuration. Instance 1: short preamble, no source check, no broadcast.
    eth_header_parser u_dut0 (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .data_i(data),
        .frame_end_i(frame_end), .exp_dst_addr_i(exp_dst), .exp_src_addr_i(exp_src),
        .exp_type_i(exp_type), .preamble_valid_o(pv[0]), .dst_addr_valid_o(dv[0]),
        .src_addr_valid_o(sv[0]), .type_length_valid_o(tv[0]), .dst_addr_o(dsto[0]),
        .src_addr_o(srco[0]), .type_length_o(tyo[0]), .parse_error_o(pe[0]),
        .err_code_o(ec[0]), .in_header_o(inh[0])
    );

    eth_header_parser #(
        .PREAMBLE_LEN(3), .CHECK_DST(1'b1), .CHECK_SRC(1'b0), .CHECK_TYPE(1'b1), .ACCEPT_BCAST(1'b0)
    ) u_dut1 (
        .clock_i(clock), .reset_i(reset), .enable_i(enable), .data_i(data),
        .frame_end_i(frame_end), .exp_dst_addr_i(exp_dst), .exp_src_addr_i(exp_src),
        .exp_type_i(exp_type), .preamble_valid_o(pv[1]), .dst_addr_valid_o(dv[1]),
        .src_addr_valid_o(sv[1]), .type_length_valid_o(tv[1]), .dst_addr_o(dsto[1]),
        .src_addr_o(srco[1]), .type_length_o(tyo[1]), .parse_error_o(pe[1]),
        .err_code_o(ec[1]), .in_header_o(inh[1])
    );

    // Reference model: header position counted in bytes after SFD (-1 = hunting preamble),
    // fields read out of a byte history once their last byte has arrived.
    int          c_len[2] = '{7, 3};
    bit          c_cd[2]  = '{1'b1, 1'b1};
    bit          c_cs[2]  = '{1'b1, 1'b0};
    bit          c_ct[2]  = '{1'b1, 1'b1};
    bit          c_bc[2]  = '{1'b1, 1'b0};
    int          m_run[2], m_pos[2];
    logic [111:0] m_hist[2];
    logic        e_pv[2], e_dv[2], e_sv[2], e_tv[2], e_pe[2], e_inh[2];
    logic [1:0]  e_ec[2];
    logic [47:0] e_dst[2], e_src[2];
    logic [15:0] e_ty[2];

    task automatic model_reset(input bit k);
        m_run[k] = 0; m_pos[k] = -1; m_hist[k] = '0;
        e_pv[k] = 0; e_dv[k] = 0; e_sv[k] = 0; e_tv[k] = 0; e_pe[k] = 0; e_inh[k] = 0;
        e_ec[k] = '0; e_dst[k] = '0; e_src[k] = '0; e_ty[k] = '0;
    endtask

    task automatic model_fail(input bit k, input logic [1:0] code);
        e_pe[k] = 1'b1; e_ec[k] = code; m_pos[k] = -1; m_run[k] = 0;
    endtask

    task automatic model_edge(input bit k);
        logic [47:0] val;
        e_pv[k] = 0; e_dv[k] = 0; e_sv[k] = 0; e_tv[k] = 0; e_pe[k] = 0;
        if (frame_end) begin
            m_pos[k] = -1; m_run[k] = 0;
        end else if (enable) begin
            if (m_pos[k] < 0) begin
                if (data == 8'h55) m_run[k] = (m_run[k] < 15) ? m_run[k] + 1 : 15;
                else if (data == 8'hD5 && m_run[k] >= c_len[k]) begin
                    e_pv[k] = 1'b1; m_pos[k] = 0; m_run[k] = 0;
                end else m_run[k] = 0;
            end else if (m_pos[k] < 14) begin
                m_hist[k] = {m_hist[k][103:0], data};
                m_pos[k] = m_pos[k] + 1;
                val = m_hist[k][47:0];
                if (m_pos[k] == 6) begin
                    if (!c_cd[k] || val == exp_dst || (c_bc[k] && val == 48'hFFFF_FFFF_FFFF)) begin
                        e_dv[k] = 1'b1; e_dst[k] = val;
                    end else model_fail(k, 2'b01);
                end else if (m_pos[k] == 12) begin
                    if (!c_cs[k] || val == exp_src) begin
                        e_sv[k] = 1'b1; e_src[k] = val;
                    end else model_fail(k, 2'b10);
                end else if (m_pos[k] == 14) begin
                    if (!c_ct[k] || val[15:0] == exp_type) begin
                        e_tv[k] = 1'b1; e_ty[k] = val[15:0];
                    end else model_fail(k, 2'b11);
                end
            end
        end
        e_inh[k] = (m_pos[k] >= 0 && m_pos[k] < 14);
    endtask

    function automatic logic [127:0] dut_vec(input bit k);
        return {8'h00, pv[k], dv[k], sv[k], tv[k], pe[k], ec[k], inh[k], dsto[k], srco[k], tyo[k]};
    endfunction

    function automatic logic [127:0] mdl_vec(input bit k);
        return {8'h00, e_pv[k], e_dv[k], e_sv[k], e_tv[k], e_pe[k], e_ec[k], e_inh[k],
                e_dst[k], e_src[k], e_ty[k]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_models(input string tag);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s model dut%0d", tag, i), dut_vec(i[0]), mdl_vec(i[0]));
    endtask

    // Inputs are driven 1 time unit after an edge; outputs are compared at the same point.
    task automatic cycle(input logic en, input logic [7:0] d, input logic fe);
        enable = en; data = d; frame_end = fe;
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_edge(i[0]);
        #1;
        check_models("cycle");
    endtask

    task automatic put(input logic [7:0] d);
        while ($urandom_range(99) < stall_pct) cycle(1'b0, 8'($urandom), 1'b0);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic send_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] ty, input int nhdr);
        logic [111:0] hdr;
        hdr = {dst, src, ty};
        repeat (npre) put(8'h55);
        put(8'hD5);
        for (int i = 0; i < nhdr; i++) put(hdr[111 - 8 * i -: 8]);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) model_reset(i[0]);
        check("reset clears dut0", dut_vec(1'b0), 128'h0);
        check_models("reset");
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       fe;
        logic [4:0] pulses;   // {preamble, dst, src, type, error}
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] fb[$];

    function automatic logic [4:0] frame_pulse(input int idx);
        case (idx)
            7:       return 5'b10000;
            13:      return 5'b01000;
            19:      return 5'b00100;
            21:      return 5'b00010;
            default: return 5'b00000;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 2; i++) model_reset(i[0]);

        repeat (7) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        for (int i = 1; i <= 6; i++) fb.push_back(8'(i));
        for (int i = 0; i < 6; i++) fb.push_back(8'hFF - 8'(i));
        fb.push_back(8'h08);
        fb.push_back(8'h00);
        // Frame 1 straight through; frame 2 with a stalled strobe before every byte.
        vecs.push_back('{1'b0, 8'h00, 1'b1, 5'b0});
        for (int i = 0; i < fb.size(); i++) vecs.push_back('{1'b1, fb[i], 1'b0, frame_pulse(i)});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 5'b0});
        for (int i = 0; i < fb.size(); i++) begin
            vecs.push_back('{1'b0, 8'hD5, 1'b0, 5'b0});
            vecs.push_back('{1'b1, fb[i], 1'b0, frame_pulse(i)});
        end

        repeat (2) @(posedge clock);
        #1;
        check("reset state dut0", dut_vec(1'b0), 128'h0);
        check_models("reset");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.en, v.d, v.fe);
            check($sformatf("vec%0d pulses", i), 128'({pv[0], dv[0], sv[0], tv[0], pe[0]}),
                  128'(v.pulses));
            if (i == fb.size() || i == vecs.size() - 1) begin
                check("dst_addr", 128'(dsto[0]), 128'(48'h010203040506));
                check("src_addr", 128'(srco[0]), 128'(48'hFFFEFDFCFBFA));
                check("type_length", 128'(tyo[0]), 128'(16'h0800));
            end
        end

        // Destination mismatch on the last byte, then a clean frame.
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(7, 48'h010203040507, exp_src, exp_type, 6);
        check("dst err pulse", 128'({pe[0], ec[0], dv[0]}), 128'(4'b1010));
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(7, exp_dst, exp_src, exp_type, 14);
        check("frame after dst err", 128'(tv[0]), 128'(1'b1));

        // Broadcast destination: accepted by dut0, rejected by dut1.
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(7, 48'hFFFF_FFFF_FFFF, exp_src, exp_type, 14);
        check("bcast accepted", 128'({tv[0], dsto[0]}), 128'({1'b1, 48'hFFFF_FFFF_FFFF}));
        check("bcast rejected code", 128'({ec[1], inh[1]}), 128'(3'b010));

        // Short preamble refused, long preamble accepted.
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(6, exp_dst, exp_src, exp_type, 0);
        check("short preamble", 128'(pv[0]), 128'(1'b0));
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(10, exp_dst, exp_src, exp_type, 0);
        check("long preamble", 128'(pv[0]), 128'(1'b1));

        // Reset during source byte 3, then a clean frame.
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(7, exp_dst, 48'h0A0B0C0D0E0F, exp_type, 9);
        do_reset();
        send_frame(7, exp_dst, exp_src, exp_type, 14);
        check("frame after reset", 128'({tv[0], srco[0]}), 128'({1'b1, exp_src}));

        // frame_end on the edge of type byte 2 drops that byte.
        cycle(1'b0, 8'h00, 1'b1);
        send_frame(7, exp_dst, exp_src, exp_type, 13);
        cycle(1'b1, exp_type[7:0], 1'b1);
        check("fe beats type byte", 128'({tv[0], pe[0], inh[0]}), 128'(3'b000));
        send_frame(7, exp_dst, exp_src, exp_type, 14);
        check("frame after fe", 128'(tv[0]), 128'(1'b1));

        // Random frames with stalls, mixed matches, truncation and occasional reset.
        stall_pct = 30;
        for (int f = 0; f < 60; f++) begin
            logic [47:0] d, s;
            logic [15:0] t;
            int r;
            if ($urandom_range(2) == 0) begin
                exp_dst = {16'($urandom), 32'($urandom)};
                exp_src = {16'($urandom), 32'($urandom)};
                exp_type = 16'($urandom);
            end
            r = int'($urandom_range(3));
            d = (r == 1) ? 48'hFFFF_FFFF_FFFF : (r == 2) ? {16'($urandom), 32'($urandom)} : exp_dst;
            s = ($urandom_range(4) == 0) ? {16'($urandom), 32'($urandom)} : exp_src;
            t = ($urandom_range(4) == 0) ? 16'($urandom) : exp_type;
            repeat ($urandom_range(3)) put(8'($urandom));
            send_frame(int'($urandom_range(12)), d, s, t,
                       ($urandom_range(3) == 0) ? int'($urandom_range(14)) : 14);
            repeat ($urandom_range(5)) put(8'($urandom));
            if ($urandom_range(19) == 0) do_reset();
            cycle(1'($urandom), 8'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- Parametrised successor to the fixed-pattern Ethernet header FSM.
- Parses a byte stream: preamble (configurable length), SFD, 6-byte destination, 6-byte source, 2-byte type/length.
- Captures each field and checks it against run-time expected values, with per-field check enables and broadcast acceptance.
- Supports enable-stall, frame-end resync and error reporting. Sits between the byte deserialiser and the frame payload logic.

Parameters:
- PREAMBLE_LEN, 7, minimum count of consecutive 8'h55 bytes required before SFD 8'hD5 (legal 1..15).
- CHECK_DST, 1, 1 = compare destination with exp_dst_addr; 0 = accept any.
- CHECK_SRC, 1, 1 = compare source with exp_src_addr; 0 = accept any.
- CHECK_TYPE, 1, 1 = compare type/length with exp_type; 0 = accept any.
- ACCEPT_BCAST, 1, 1 = destination 48'hFFFF_FFFF_FFFF passes regardless of exp_dst_addr.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  byte strobe; data is consumed only on edges where enable=1.
- data  in  8  stream byte.
- frame_end  in  1  end-of-frame pulse; returns parser to PREAMBLE.
- exp_dst_addr  in  48  expected destination (first byte on wire = [47:40]).
- exp_src_addr  in  48  expected source.
- exp_type  in  16  expected type/length.
- preamble_valid  out  1  1-cycle pulse: preamble+SFD accepted.
- dst_addr_valid  out  1  1-cycle pulse: destination accepted.
- src_addr_valid  out  1  1-cycle pulse: source accepted.
- type_length_valid  out  1  1-cycle pulse: type accepted; header complete.
- dst_addr  out  48  captured destination, updated with dst_addr_valid.
- src_addr  out  48  captured source, updated with src_addr_valid.
- type_length  out  16  captured type/length, updated with type_length_valid.
- parse_error  out  1  1-cycle pulse on field mismatch.
- err_code  out  2  01 = dst, 10 = src, 11 = type; held until next error or reset.
- in_header  out  1  high in states DST, SRC, TYPE.

Behaviour:
- Reset (async): state = PREAMBLE, pre_cnt = 0, byte_cnt = 0. All pulses, captured fields, err_code and in_header are 0.
- States: PREAMBLE, DST, SRC, TYPE, DONE. pre_cnt saturates at 15; byte_cnt is 3 bits.
- Every output is registered. A pulse is high for exactly the one cycle after the edge that sampled the completing byte. Pulses are 0 on all other cycles, including stalled ones.
- enable=0: state, counters and shift registers hold; no pulses.
- PREAMBLE:
  - 8'h55 -> pre_cnt++ (saturating).
  - 8'hD5 with pre_cnt >= PREAMBLE_LEN -> preamble_valid, go to DST, byte_cnt = 0.
  - 8'hD5 with pre_cnt < PREAMBLE_LEN, or any other byte -> pre_cnt = 0.
  - Preamble failures never raise parse_error.
  - A preamble longer than PREAMBLE_LEN is accepted.
- DST/SRC: each byte is shifted in MSB-first; byte_cnt counts 0..5. On byte 5 the full value {shift[39:0], data} is compared.
  - Pass -> field register loads, valid pulse, next state (DST->SRC, SRC->TYPE), byte_cnt = 0.
  - Fail -> parse_error, err_code set, state = PREAMBLE, pre_cnt = 0.
- DST pass condition: !CHECK_DST, or value == exp_dst_addr, or (ACCEPT_BCAST and value == all-ones).
- TYPE: 2 bytes, same pass/fail rule. Pass -> type_length_valid, go to DONE.
- DONE: bytes ignored (payload); in_header = 0.
- Expected-value ports are sampled only on the completing byte's edge.
- frame_end=1 on any edge, enable irrelevant -> state = PREAMBLE, pre_cnt = 0, byte_cnt = 0, no pulses. frame_end beats a simultaneous completing byte: that byte is dropped and no valid or error pulse is produced.
- Reset mid-frame: immediate return to reset values. Captured fields are cleared.
- Back-to-back frames: after frame_end, the very next enabled byte is treated as preamble.

Test Plan:
- Reset, then 7x55, D5, 01..06, FF FE FD FC FB FA, 08 00 with matching expected values. Required: each valid pulses once, one cycle after its last byte; dst_addr = 48'h010203040506, src_addr = 48'hFFFEFDFCFBFA, type_length = 16'h0800.
- Same frame with enable toggled 0/1 between every byte. Required: identical captured values; pulses only after enabled completing bytes.
- Destination byte 6 = 07 with CHECK_DST = 1. Required: parse_error pulse, err_code = 01, no dst_addr_valid. A following valid frame parses normally.
- Destination FF x6 with ACCEPT_BCAST = 1. Required: dst_addr_valid. With ACCEPT_BCAST = 0. Required: error code 01.
- Preamble of 6x55 then D5. Required: no preamble_valid. Preamble of 10x55 then D5. Required: preamble_valid.
- Assert reset during SRC byte 3, and separately frame_end on the type byte 2 edge. Required in both cases: no pulses, state = PREAMBLE, next frame accepted.
